keypad_emulator: RTL and testbench

Synthesizable 4x4 matrix-keypad emulator: the physical-keypad end of the row-scan / column-sense interface driven by the keypad scanner controller. It accepts a key-press request (4-bit key code) and answers the scanner's active-low row drive with active-low column levels. The press is optionally framed by deterministic contact bounce, held for a fixed time, then released and followed by a mandatory gap. It serves as an on-board loopback and self-test source and as a bench stimulus for the scanner.

---
 rtl/keypad_emulator_if.sv | 19 +
 rtl/keypad_emulator.sv | 139 +++++++++++++
 tb/tb_keypad_emulator.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/keypad_emulator_if.sv
// Request/handshake bundle between a key-press requester and the keypad emulator.
interface keypad_emulator_if;
  logic       req_valid;
  logic [3:0] req_code;
  logic       bounce_en;
  logic       req_ready;
  logic       busy;
  logic       done;

  modport master (
    output req_valid, req_code, bounce_en,
    input  req_ready, busy, done
  );

  modport slave (
    input  req_valid, req_code, bounce_en,
    output req_ready, busy, done
  );
endinterface

// File: rtl/keypad_emulator.sv
// 4x4 matrix-keypad emulator: answers active-low row drive with active-low column
// levels for one requested key, with optional deterministic contact bounce.
module keypad_emulator #(
  parameter int unsigned HOLD_CYCLES   = 5000000,
  parameter int unsigned BOUNCE_CYCLES = 200000,
  parameter int unsigned BOUNCE_TOGGLE = 1000,
  parameter int unsigned GAP_CYCLES    = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       linhaN,
  output logic [3:0]       colunaN,
  keypad_emulator_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    BOUNCE_IN,
    HOLD,
    BOUNCE_OUT,
    GAP
  } state_t;

  state_t      state;
  logic        contact;
  logic        bnc;
  logic        done_q;
  logic [1:0]  row;
  logic [1:0]  col;
  logic [31:0] phase_cnt;
  logic [31:0] tog_cnt;
  logic [1:0]  code_row;
  logic [1:0]  code_col;
  logic [3:0]  col_next;
  logic        bounce_req;

  assign bus.req_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
  assign bounce_req    = bus.bounce_en && (BOUNCE_CYCLES != 0);

  always_comb begin
    code_row = 2'd0;
    code_col = 2'd0;
    case (bus.req_code)
      4'h1: begin code_row = 2'd0; code_col = 2'd0; end
      4'h2: begin code_row = 2'd0; code_col = 2'd1; end
      4'h3: begin code_row = 2'd0; code_col = 2'd2; end
      4'hA: begin code_row = 2'd0; code_col = 2'd3; end
      4'h4: begin code_row = 2'd1; code_col = 2'd0; end
      4'h5: begin code_row = 2'd1; code_col = 2'd1; end
      4'h6: begin code_row = 2'd1; code_col = 2'd2; end
      4'hB: begin code_row = 2'd1; code_col = 2'd3; end
      4'h7: begin code_row = 2'd2; code_col = 2'd0; end
      4'h8: begin code_row = 2'd2; code_col = 2'd1; end
      4'h9: begin code_row = 2'd2; code_col = 2'd2; end
      4'hC: begin code_row = 2'd2; code_col = 2'd3; end
      4'hF: begin code_row = 2'd3; code_col = 2'd0; end
      4'h0: begin code_row = 2'd3; code_col = 2'd1; end
      4'hE: begin code_row = 2'd3; code_col = 2'd2; end
      default: begin code_row = 2'd3; code_col = 2'd3; end
    endcase
  end

  // Only the latched key's row matters; other rows low never close anything.
  always_comb begin
    col_next = '1;
    if (contact && !linhaN[row]) col_next[col] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      contact   <= 1'b0;
      bnc       <= 1'b0;
      done_q    <= 1'b0;
      row       <= '0;
      col       <= '0;
      phase_cnt <= '0;
      tog_cnt   <= '0;
      colunaN   <= '1;
    end else begin
      colunaN <= col_next;
      done_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            row       <= code_row;
            col       <= code_col;
            bnc       <= bounce_req;
            contact   <= 1'b1;
            phase_cnt <= '0;
            tog_cnt   <= '0;
            state     <= bounce_req ? BOUNCE_IN : HOLD;
          end
        end
        BOUNCE_IN, BOUNCE_OUT: begin
          // Window end wins over a coincident toggle so the exit level is fixed.
          if (phase_cnt == BOUNCE_CYCLES - 1) begin
            phase_cnt <= '0;
            tog_cnt   <= '0;
            contact   <= (state == BOUNCE_IN);
            state     <= (state == BOUNCE_IN) ? HOLD : GAP;
          end else begin
            phase_cnt <= phase_cnt + 32'd1;
            if (tog_cnt == BOUNCE_TOGGLE - 1) begin
              contact <= ~contact;
              tog_cnt <= '0;
            end else begin
              tog_cnt <= tog_cnt + 32'd1;
            end
          end
        end
        HOLD: begin
          if (phase_cnt == HOLD_CYCLES - 1) begin
            phase_cnt <= '0;
            tog_cnt   <= '0;
            contact   <= 1'b0;
            state     <= bnc ? BOUNCE_OUT : GAP;
          end else begin
            phase_cnt <= phase_cnt + 32'd1;
          end
        end
        GAP: begin
          if (phase_cnt == GAP_CYCLES - 1) begin
            phase_cnt <= '0;
            tog_cnt   <= '0;
            done_q    <= 1'b1;
            state     <= IDLE;
          end else begin
            phase_cnt <= phase_cnt + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed scoreboard bench for keypad_emulator with short hold/bounce/gap timing.
module tb_keypad_emulator;
  localparam int H = 20;
  localparam int B = 8;
  localparam int T = 2;
  localparam int G = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] lin = 4'b1111;
  logic [3:0] col;

  keypad_emulator_if kif();

  keypad_emulator #(
    .HOLD_CYCLES  (H),
    .BOUNCE_CYCLES(B),
    .BOUNCE_TOGGLE(T),
    .GAP_CYCLES   (G)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .linhaN (lin),
    .colunaN(col),
    .bus    (kif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [3:0] col;
    logic       done;
    logic       busy;
    logic       ready;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Key map indexed by code 0..F.
  int krow[16] = '{3, 0, 0, 0, 1, 1, 1, 2, 2, 2, 0, 1, 2, 3, 3, 3};
  int kcol[16] = '{1, 0, 1, 2, 0, 1, 2, 0, 1, 2, 3, 3, 3, 3, 2, 0};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [3:0] c, input logic d, input logic b);
    exp_t e;
    e.tag = tag; e.col = c; e.done = d; e.busy = b; e.ready = ~b;
    sbq.push_back(e);
  endtask

  task automatic sb_check;
    exp_t e;
    if (sbq.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL sb_empty observed=0 entries expected=1");
    end else begin
      e = sbq.pop_front();
      chk({e.tag, "_col"},   col,                     e.col);
      chk({e.tag, "_done"},  {3'b000, kif.done},      {3'b000, e.done});
      chk({e.tag, "_busy"},  {3'b000, kif.busy},      {3'b000, e.busy});
      chk({e.tag, "_ready"}, {3'b000, kif.req_ready}, {3'b000, e.ready});
    end
  endtask

  // Contact level during cycle E0+c of a press sequence.
  function automatic logic contact_at(input logic bnc, input int c);
    if (!bnc) return c < H;
    if (c < B) return ((c / T) % 2) == 0;
    if (c < B + H) return 1'b1;
    if (c < 2 * B + H) return (((c - B - H) / T) % 2) == 1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] col_exp(input logic [3:0] code, input logic ct, input logic [3:0] l);
    logic [3:0] m;
    m = 4'b1111;
    if (ct && l[krow[code]] == 1'b0) m[kcol[code]] = 1'b0;
    return m;
  endfunction

  function automatic logic [3:0] lin_at(input logic sweep, input logic [3:0] fixed, input int k);
    logic [3:0] one;
    one = 4'b0001 << (k % 4);
    return sweep ? ~one : fixed;
  endfunction

  // Accepts code at the next edge (E0) and checks every cycle through the done cycle.
  task automatic press(input string tag, input logic [3:0] code, input logic bnc,
                       input logic [3:0] lfix, input logic sweep,
                       input logic keep, input logic [3:0] nxt);
    int d;
    d = bnc ? (2 * B + H + G) : (H + G);
    kif.req_valid = 1'b1;
    kif.req_code  = code;
    kif.bounce_en = bnc;
    tick;
    if (keep) kif.req_code = nxt;
    else kif.req_valid = 1'b0;
    kif.bounce_en = ~bnc;
    lin = lin_at(sweep, lfix, 0);
    for (int k = 1; k <= d; k++) begin
      push(tag, col_exp(code, contact_at(bnc, k - 1), lin), k == d, k < d);
      tick;
      lin = lin_at(sweep, lfix, k);
      sb_check;
    end
  endtask

  initial begin
    kif.req_valid = 1'b0;
    kif.req_code  = 4'h0;
    kif.bounce_en = 1'b0;

    // Reset state and idle row scanning.
    tick;
    push("reset", 4'b1111, 1'b0, 1'b0);
    tick;
    sb_check;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      lin = lin_at(1'b1, 4'b1111, i);
      push("idle_scan", 4'b1111, 1'b0, 1'b0);
      tick;
      sb_check;
    end

    press("k5_row1", 4'h5, 1'b0, 4'b1101, 1'b0, 1'b0, 4'h0);
    press("k5_row0", 4'h5, 1'b0, 4'b1110, 1'b0, 1'b0, 4'h0);
    press("kD_bounce", 4'hD, 1'b1, 4'b0111, 1'b0, 1'b0, 4'h0);

    for (int c = 0; c < 16; c++)
      press("sweep_all", 4'(c), 1'b0, 4'b0000, 1'b0, 1'b0, 4'h0);
    for (int c = 0; c < 16; c++)
      press("sweep_rows", 4'(c), 1'b0, 4'b1111, 1'b1, 1'b0, 4'h0);

    // Back-to-back: code 0 held on req_code is taken in the done cycle of code 3.
    press("b2b_k3", 4'h3, 1'b0, 4'b0000, 1'b0, 1'b1, 4'h0);
    press("b2b_k0", 4'h0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'h0);

    // Reset during HOLD aborts the press.
    kif.req_valid = 1'b1;
    kif.req_code  = 4'h9;
    kif.bounce_en = 1'b0;
    lin = 4'b0000;
    tick;
    kif.req_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      push("rst_hold", col_exp(4'h9, contact_at(1'b0, k - 1), lin), 1'b0, 1'b1);
      tick;
      sb_check;
    end
    rst = 1'b1;
    push("rst_abort", 4'b1111, 1'b0, 1'b0);
    tick;
    sb_check;
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      push("rst_idle", 4'b1111, 1'b0, 1'b0);
      tick;
      sb_check;
    end
    press("rst_new", 4'h9, 1'b0, 4'b0000, 1'b0, 1'b0, 4'h0);

    n_cmp++;
    assert (sbq.size() == 0) else begin
      n_bad++;
      $error("FAIL sb_leftover observed=%0d expected=0", sbq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
